// File: rtl/explosion_anim_ctrl_pkg.sv
// Shared types and helpers for the spaceship explosion sprite sequencer.
package explosion_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    FINISH = 2'd2
  } expl_state_t;

  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

  // Counter width that stays >= 1 bit even when the count range is a single value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/explosion_anim_ctrl_if.sv
// Control, pixel and ROM bus between the video pipeline and the explosion sequencer.
interface explosion_anim_ctrl_if #(
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 12
);
  logic               frame_tick;
  logic               trigger;
  logic [COORD_W-1:0] pos_x;
  logic [COORD_W-1:0] pos_y;
  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic [ADDR_W-1:0]  rom_addr;
  logic [3:0]         rom_data;
  logic [3:0]         pal_index;
  logic               explosion_on;
  logic               busy;
  logic               done;

  modport master (
    output frame_tick, trigger, pos_x, pos_y, DrawX, DrawY, rom_data,
    input  rom_addr, pal_index, explosion_on, busy, done
  );

  modport slave (
    input  frame_tick, trigger, pos_x, pos_y, DrawX, DrawY, rom_data,
    output rom_addr, pal_index, explosion_on, busy, done
  );
endinterface

// File: rtl/explosion_anim_ctrl_pixel_pipe.sv
// Per-pixel hit test and three-stage ROM address / palette index pipeline.
module explosion_pixel_pipe
  import explosion_pkg::*;
#(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int COORD_W  = 10,
  parameter int ADDR_W   = 12,
  parameter int FRAME_W  = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               busy,
  input  logic [FRAME_W-1:0] frame,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic [3:0]         rom_data,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic [3:0]         pal_index,
  output logic               explosion_on
);

  localparam logic [COORD_W:0]  SW_EXT     = (COORD_W+1)'(SPRITE_W);
  localparam logic [COORD_W:0]  SH_EXT     = (COORD_W+1)'(SPRITE_H);
  localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(SPRITE_W * SPRITE_H);
  localparam logic [ADDR_W-1:0] ROW_SIZE   = ADDR_W'(SPRITE_W);

  logic [COORD_W:0]   x_end, y_end;
  logic [COORD_W-1:0] dx, dy;
  logic [ADDR_W-1:0]  addr_nxt;
  logic               hit, hit_d1, hit_d2;

  // Right/bottom edges carry an extra bit so a sprite near 2**COORD_W cannot wrap to 0.
  assign x_end = {1'b0, px} + SW_EXT;
  assign y_end = {1'b0, py} + SH_EXT;

  assign hit = busy
            && (draw_x >= px) && ({1'b0, draw_x} < x_end)
            && (draw_y >= py) && ({1'b0, draw_y} < y_end);

  assign dx       = draw_x - px;
  assign dy       = draw_y - py;
  assign addr_nxt = ADDR_W'(frame) * FRAME_SIZE + ADDR_W'(dy) * ROW_SIZE + ADDR_W'(dx);

  // NOTE: valid bits and data registers are all reset so no stale pixel leaves the pipe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr     <= '0;
      hit_d1       <= 1'b0;
      hit_d2       <= 1'b0;
      pal_index    <= '0;
      explosion_on <= 1'b0;
    end else begin
      rom_addr     <= hit ? addr_nxt : '0;
      hit_d1       <= hit;
      hit_d2       <= hit_d1;
      pal_index    <= hit_d2 ? rom_data : '0;
      explosion_on <= hit_d2 && (rom_data != TRANSPARENT_IDX);
    end
  end

endmodule

// File: rtl/explosion_anim_ctrl.sv
// Explosion animation sequencer: trigger latches position, then plays NUM_FRAMES
// frames of TICKS_PER_FRAME vsync ticks each while the pixel pipe addresses the ROM.
module explosion_anim_ctrl
  import explosion_pkg::*;
#(
  parameter int SPRITE_W        = 32,
  parameter int SPRITE_H        = 32,
  parameter int NUM_FRAMES      = 4,
  parameter int TICKS_PER_FRAME = 6,
  parameter int COORD_W         = 10,
  parameter int ADDR_W          = 12
) (
  input logic                  Clk,
  input logic                  Reset,
  explosion_anim_ctrl_if.slave bus
);

  localparam int FRAME_W = cnt_w(NUM_FRAMES);
  localparam int TICK_W  = cnt_w(TICKS_PER_FRAME);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICKS_PER_FRAME - 1);

  expl_state_t        state, state_nxt;
  logic [FRAME_W-1:0] frame;
  logic [TICK_W-1:0]  tick_cnt;
  logic [COORD_W-1:0] px, py;
  logic               busy, done;
  logic               tick_last, frame_last;

  assign tick_last  = (tick_cnt == TICK_LAST);
  assign frame_last = (frame == FRAME_LAST);

  // NOTE: sequential state is only ever written with non-blocking assignments.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.trigger) state_nxt = PLAY;
      PLAY:    if (!bus.trigger && bus.frame_tick && tick_last && frame_last)
                 state_nxt = FINISH;
      FINISH:  state_nxt = bus.trigger ? PLAY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == PLAY);
    done = (state == FINISH);
  end

  // A trigger in any state restarts from frame 0 and wins over a coincident tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame    <= '0;
      tick_cnt <= '0;
      px       <= '0;
      py       <= '0;
    end else if (bus.trigger) begin
      frame    <= '0;
      tick_cnt <= '0;
      px       <= bus.pos_x;
      py       <= bus.pos_y;
    end else if (state == PLAY && bus.frame_tick) begin
      if (tick_last) begin
        tick_cnt <= '0;
        if (!frame_last) frame <= frame + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  explosion_pixel_pipe #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H),
    .COORD_W  (COORD_W),
    .ADDR_W   (ADDR_W),
    .FRAME_W  (FRAME_W)
  ) u_pixel_pipe (
    .Clk          (Clk),
    .Reset        (Reset),
    .busy         (busy),
    .frame        (frame),
    .px           (px),
    .py           (py),
    .draw_x       (bus.DrawX),
    .draw_y       (bus.DrawY),
    .rom_data     (bus.rom_data),
    .rom_addr     (bus.rom_addr),
    .pal_index    (bus.pal_index),
    .explosion_on (bus.explosion_on)
  );

  assign bus.busy = busy;
  assign bus.done = done;

endmodule

// File: tb/tb_explosion_anim_ctrl.sv
// Scoreboard bench for explosion_anim_ctrl: a cycle model queues expected ROM
// addresses and pixel outputs, which are popped when their pipeline slot comes due.
module tb_explosion_anim_ctrl;

  localparam int SW = 32;
  localparam int SH = 32;
  localparam int NF = 4;
  localparam int TP = 6;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  explosion_anim_ctrl_if #(.COORD_W(10), .ADDR_W(12)) bus ();

  explosion_anim_ctrl #(
    .SPRITE_W(SW), .SPRITE_H(SH), .NUM_FRAMES(NF), .TICKS_PER_FRAME(TP),
    .COORD_W(10), .ADDR_W(12)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Synchronous sprite ROM: contents are simply the low nibble of the address.
  always @(posedge Clk) bus.rom_data <= bus.rom_addr[3:0];

  typedef struct {int due; int val;} addr_exp_t;
  typedef struct {int due; int pal; int on;} pix_exp_t;
  addr_exp_t addr_q[$];
  pix_exp_t  pix_q[$];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int m_st   = 0;   // 0 idle, 1 play, 2 finish
  int m_frame, m_tick, m_px, m_py;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
  endtask

  task automatic set_pix(input int x, input int y);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
  endtask

  task automatic rnd_pix();
    set_pix(m_px - 4 + int'($urandom_range(0, 40)), m_py - 4 + int'($urandom_range(0, 40)));
  endtask

  // One clock: drive inputs, queue expectations, advance the model, compare due items.
  task automatic cycle(input bit trig, input bit ftick, input bit rst);
    int n, x, y, addr, pal;
    bit hit;
    addr_exp_t ae;
    pix_exp_t  pe;
    bus.trigger    = trig;
    bus.frame_tick = ftick;
    Reset          = rst;
    x = int'(bus.DrawX);
    y = int'(bus.DrawY);
    n = cyc + 1;
    if (rst) begin
      addr_q.delete();
      pix_q.delete();
      addr_q.push_back('{n, 0});
      for (int k = 0; k < 3; k++) pix_q.push_back('{n + k, 0, 0});
    end else begin
      hit  = (m_st == 1) && x >= m_px && x < m_px + SW && y >= m_py && y < m_py + SH;
      addr = hit ? m_frame * SW * SH + (y - m_py) * SW + (x - m_px) : 0;
      pal  = hit ? addr % 16 : 0;
      addr_q.push_back('{n, addr});
      pix_q.push_back('{n + 2, pal, (pal != 0) ? 1 : 0});
    end

    @(posedge Clk);
    cyc++;
    if (rst) begin
      m_st = 0; m_frame = 0; m_tick = 0; m_px = 0; m_py = 0;
    end else if (trig) begin
      m_st = 1; m_frame = 0; m_tick = 0;
      m_px = int'(bus.pos_x); m_py = int'(bus.pos_y);
    end else if (m_st == 1) begin
      if (ftick) begin
        if (m_tick == TP - 1) begin
          m_tick = 0;
          if (m_frame == NF - 1) m_st = 2;
          else m_frame++;
        end else begin
          m_tick++;
        end
      end
    end else begin
      m_st = 0;
    end

    @(negedge Clk);
    check("busy", int'(bus.busy), (m_st == 1) ? 1 : 0);
    check("done", int'(bus.done), (m_st == 2) ? 1 : 0);
    while (addr_q.size() > 0 && addr_q[0].due == cyc) begin
      ae = addr_q.pop_front();
      check("rom_addr", int'(bus.rom_addr), ae.val);
    end
    while (pix_q.size() > 0 && pix_q[0].due == cyc) begin
      pe = pix_q.pop_front();
      check("pal_index", int'(bus.pal_index), pe.pal);
      check("explosion_on", int'(bus.explosion_on), pe.on);
    end
  endtask

  task automatic run_ticks(input int k);
    repeat (k) begin
      repeat (2) begin
        rnd_pix();
        cycle(1'b0, 1'b0, 1'b0);
      end
      rnd_pix();
      cycle(1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic pix(input int x, input int y);
    set_pix(x, y);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    m_frame = 0; m_tick = 0; m_px = 0; m_py = 0;
    Reset = 1'b1;
    bus.trigger = 1'b0;
    bus.frame_tick = 1'b0;
    bus.pos_x = '0;
    bus.pos_y = '0;
    set_pix(0, 0);
    @(negedge Clk);

    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    pix(100, 50);
    pix(110, 60);

    // Start at (100,50); the coincident tick must be ignored.
    bus.pos_x = 10'd100;
    bus.pos_y = 10'd50;
    set_pix(100, 50);
    cycle(1'b1, 1'b1, 1'b0);
    pix(100, 50);
    pix(109, 50);
    pix(131, 81);
    pix(132, 50);
    pix(99, 50);
    pix(100, 82);

    run_ticks(18);
    pix(131, 81);
    pix(116, 66);

    // Restart on the final tick of frame 3: trigger wins, no done.
    run_ticks(5);
    bus.pos_x = 10'd200;
    bus.pos_y = 10'd300;
    set_pix(131, 81);
    cycle(1'b1, 1'b1, 1'b0);
    pix(200, 300);
    pix(231, 331);

    // Full 24-tick run, then a trigger in the FINISH cycle at the screen edge.
    run_ticks(24);
    bus.pos_x = 10'd1000;
    bus.pos_y = 10'd0;
    set_pix(1000, 0);
    cycle(1'b1, 1'b0, 1'b0);
    pix(1023, 0);
    pix(5, 0);
    pix(999, 0);
    pix(1023, 31);
    pix(1023, 32);
    pix(1009, 0);

    // Reset in the middle of frame 2 squashes the pipe and returns to frame 0.
    run_ticks(12);
    set_pix(1009, 0);
    cycle(1'b0, 1'b0, 1'b1);
    pix(1009, 0);
    pix(1009, 0);
    bus.pos_x = 10'd100;
    bus.pos_y = 10'd50;
    set_pix(100, 50);
    cycle(1'b1, 1'b0, 1'b0);
    pix(100, 50);
    pix(109, 50);
    repeat (4) pix(0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
